mfp_pmod_spi_scheduler: RTL



---
 rtl/mfp_pmod_spi_pkg.sv | 38 +++
 rtl/mfp_pmod_spi_shifter.sv | 77 +++++++
 rtl/mfp_pmod_spi_scheduler.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/mfp_pmod_spi_pkg.sv
// Shared types and helpers for the PMOD SPI multi-sensor read scheduler.
// Holds the FSM encoding, frame width and the round-robin channel search.
package mfp_pmod_spi_pkg;

    localparam int unsigned FRAME_BITS = 16;
    localparam int unsigned MAX_CH     = 8;
    localparam int unsigned CH_W       = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } state_e;

    // First set mask bit strictly after last, searching upward with wrap over n_ch channels.
    function automatic logic [CH_W-1:0] rr_next(
        input logic [MAX_CH-1:0] mask,
        input logic [CH_W-1:0]   last,
        input int unsigned       n_ch
    );
        logic [CH_W-1:0] pick;
        logic            found;
        int unsigned     idx;
        pick  = last;
        found = 1'b0;
        for (int unsigned i = 1; i <= MAX_CH; i++) begin
            idx = (32'(last) + i) % n_ch;
            if (!found && (i <= n_ch) && mask[idx[CH_W-1:0]]) begin
                pick  = idx[CH_W-1:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/mfp_pmod_spi_shifter.sv
// SPI read engine: generates FRAME_BITS sck periods (low then high), samples sdo
// as sck rises and shifts MSB first; done_c pulses on the last cycle of the final high phase.
module mfp_pmod_spi_shifter
    import mfp_pmod_spi_pkg::*;
#(
    parameter int unsigned SCK_DIV = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic                  sdo_i,
    output logic                  sck_o,
    output logic                  done_c,
    output logic [FRAME_BITS-1:0] data_o
);

    localparam int unsigned DIV_W = $clog2(SCK_DIV);
    localparam int unsigned BIT_W = $clog2(FRAME_BITS);

    logic                  active_q, active_d;
    logic                  sck_q,    sck_d;
    logic [DIV_W-1:0]      div_q,    div_d;
    logic [BIT_W-1:0]      bit_q,    bit_d;
    logic [FRAME_BITS-1:0] shift_q,  shift_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            active_q <= 1'b0;
            sck_q    <= 1'b1;
            div_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
        end else begin
            active_q <= active_d;
            sck_q    <= sck_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
        end
    end

    always_comb begin
        active_d = active_q;
        sck_d    = sck_q;
        div_d    = div_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        done_c   = 1'b0;
        if (!active_q) begin
            if (start_i) begin
                active_d = 1'b1;
                sck_d    = 1'b0;
                div_d    = '0;
                bit_d    = '0;
            end
        end else if (div_q == DIV_W'(SCK_DIV - 1)) begin
            div_d = '0;
            if (!sck_q) begin
                // sck rises on this edge: capture the bit the sensor set up on the fall
                sck_d   = 1'b1;
                shift_d = {shift_q[FRAME_BITS-2:0], sdo_i};
            end else if (bit_q == BIT_W'(FRAME_BITS - 1)) begin
                active_d = 1'b0;
                done_c   = 1'b1;
            end else begin
                sck_d = 1'b0;
                bit_d = bit_q + BIT_W'(1);
            end
        end else begin
            div_d = div_q + DIV_W'(1);
        end
    end

    assign sck_o  = sck_q;
    assign data_o = shift_q;

endmodule

// File: rtl/mfp_pmod_spi_scheduler.sv
// Round-robin scheduler sharing one PMOD SPI bus between N_CH read-only 16-bit sensors.
// Owns chip selects, setup/hold/gap timing and the per-channel sample registers.
module mfp_pmod_spi_scheduler
    import mfp_pmod_spi_pkg::*;
#(
    parameter int unsigned N_CH       = 2,
    parameter int unsigned SCK_DIV    = 8,
    parameter int unsigned GAP_CYCLES = 256
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [N_CH-1:0]            ch_mask,
    output logic [N_CH-1:0]            cs_n,
    output logic                       sck,
    input  logic                       sdo,
    output logic [N_CH*FRAME_BITS-1:0] values,
    output logic                       value_valid,
    output logic [CH_W-1:0]            value_ch,
    output logic [FRAME_BITS-1:0]      value,
    output logic                       busy
);

    localparam int unsigned CNT_MAX = (GAP_CYCLES > SCK_DIV) ? GAP_CYCLES : SCK_DIV;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX);
    localparam int unsigned VALS_W  = N_CH * FRAME_BITS;

    state_e                state_q,    state_d;
    logic [CNT_W-1:0]      cnt_q,      cnt_d;
    logic [CH_W-1:0]       ch_q,       ch_d;
    logic [CH_W-1:0]       last_q,     last_d;
    logic [N_CH-1:0]       cs_n_q,     cs_n_d;
    logic [VALS_W-1:0]     values_q,   values_d;
    logic [FRAME_BITS-1:0] value_q,    value_d;
    logic [CH_W-1:0]       value_ch_q, value_ch_d;
    logic                  valid_q,    valid_d;
    logic                  busy_q,     busy_d;

    logic                  start_c;
    logic                  shift_done_c;
    logic [CH_W-1:0]       sel_c;
    logic [FRAME_BITS-1:0] shift_data;

    mfp_pmod_spi_shifter #(
        .SCK_DIV (SCK_DIV)
    ) u_shifter (
        .clock   (clock),
        .reset   (reset),
        .start_i (start_c),
        .sdo_i   (sdo),
        .sck_o   (sck),
        .done_c  (shift_done_c),
        .data_o  (shift_data)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            ch_q       <= '0;
            last_q     <= CH_W'(N_CH - 1);
            cs_n_q     <= '1;
            values_q   <= '0;
            value_q    <= '0;
            value_ch_q <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ch_q       <= ch_d;
            last_q     <= last_d;
            cs_n_q     <= cs_n_d;
            values_q   <= values_d;
            value_q    <= value_d;
            value_ch_q <= value_ch_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ch_d       = ch_q;
        last_d     = last_q;
        cs_n_d     = cs_n_q;
        values_d   = values_q;
        value_d    = value_q;
        value_ch_d = value_ch_q;
        valid_d    = 1'b0;
        start_c    = 1'b0;
        sel_c      = rr_next(MAX_CH'(ch_mask), last_q, N_CH);

        case (state_q)
            ST_IDLE: begin
                // mask and enable are only looked at here; a running frame is never retargeted
                if (enable && (|ch_mask)) begin
                    ch_d    = sel_c;
                    cs_n_d  = ~(N_CH'(1) << sel_c);
                    cnt_d   = '0;
                    state_d = ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (cnt_q == CNT_W'(SCK_DIV - 1)) begin
                    start_c = 1'b1;
                    state_d = ST_SHIFT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SHIFT: begin
                if (shift_done_c) begin
                    cnt_d   = '0;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (cnt_q == CNT_W'(SCK_DIV - 1)) begin
                    cs_n_d     = '1;
                    value_d    = shift_data;
                    value_ch_d = ch_q;
                    valid_d    = 1'b1;
                    last_d     = ch_q;
                    for (int unsigned i = 0; i < N_CH; i++) begin
                        if (ch_q == CH_W'(i)) begin
                            values_d[i*FRAME_BITS +: FRAME_BITS] = shift_data;
                        end
                    end
                    cnt_d   = '0;
                    state_d = ST_GAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign cs_n        = cs_n_q;
    assign values      = values_q;
    assign value       = value_q;
    assign value_ch    = value_ch_q;
    assign value_valid = valid_q;
    assign busy        = busy_q;

endmodule
